sb_event_queue: RTL and testbench
=================================

# sb_event_queue

Buffers decoded keyboard events and volume/mute state from the sound-box top (`NextSoundBox`) in the clk27 domain, for the system CPU to read without loss. It sits directly downstream of `NextSoundBox` on its `latest_keycode*`, `is_muted` and `volume_db*` outputs. It presents a first-word-fall-through key FIFO with a pop handshake, a sticky overflow flag, and a latched volume-status register with a change flag.

## Interface
Parameters:
- `DEPTH`, 16: key FIFO entries; must be a power of 2, at least 2.
- `AW`, 4: log2(`DEPTH`).

Ports:
- `clk27`, in, 1: the only clock.
- `hw_reset_n`, in, 1: reset, asynchronous assert, active-low.
- `keycode`, in, 16: key event from `NextSoundBox`.
- `keycode_valid`, in, 1: level input; one event is taken per rising edge.
- `is_muted`, in, 1: mute state.
- `volume_db`, in, 12: {L[5:0], R[5:0]} attenuation in dB.
- `volume_db_valid`, in, 1: level input; a volume update is taken per rising edge.
- `pop`, in, 1: CPU consumes the head entry.
- `rd_keycode`, out, 16: head entry; meaningful only while `rd_valid` is 1.
- `rd_valid`, out, 1: FIFO not empty.
- `fifo_count`, out, AW+1: number of stored entries, 0..DEPTH.
- `overflow`, out, 1: sticky; set when a push is dropped.
- `clr_overflow`, in, 1: clears `overflow`.
- `vol_status`, out, 13: {muted, L[5:0], R[5:0]}.
- `vol_changed`, out, 1: set when `vol_status` updates.
- `vol_ack`, in, 1: clears `vol_changed`.

## Operation
- **Edge detect.** `kv_q` and `vv_q` register `keycode_valid` and `volume_db_valid`.
  - `push = keycode_valid & ~kv_q`; `vupd = volume_db_valid & ~vv_q`.
  - Both registers reset to 1, so an input held high through reset release produces no event.
- **Push.** `keycode` is written at the tail on a `push` edge.
  - If count==DEPTH and no accepted pop in the same cycle, the entry is dropped and `overflow` is set.
- **Pop.** A pop is accepted only when `rd_valid`==1; the head advances.
  - A pop while empty is ignored: no pointer or count change.
- **Simultaneous push and pop.**
  - Full: both take effect; count stays DEPTH; no overflow.
  - Empty: the push is accepted, the pop is ignored; count becomes 1.
  - Otherwise: count is unchanged and both pointers advance.
- **Pointers.** AW-bit pointers wrap modulo DEPTH. `fifo_count` is a separate AW+1-bit counter; full is count==DEPTH.
- **Overflow flag.** If `clr_overflow` and a new drop occur in the same cycle, set wins.
- **Volume update.**
  - On `vupd`, {`is_muted`, `volume_db`} is latched into `vol_status` and `vol_changed` is set.
  - A change of `is_muted` versus `vol_status[12]` with no `vupd` also updates bit 12 and sets `vol_changed`.
- **Volume flag.** `vol_ack` clears `vol_changed`; an update in the same cycle wins and the flag stays 1.
- **Reset.** All state clears immediately on reset assertion; reset mid-operation discards queued entries.

## Timing
- **Reset values:** `rd_keycode`=0, `rd_valid`=0, `fifo_count`=0, `overflow`=0, `vol_status`=0, `vol_changed`=0.
- **Push latency.** `keycode_valid` is first sampled high at edge N. After edge N, `rd_valid`=1, `fifo_count` has incremented, and `rd_keycode` equals the `keycode` sampled at edge N (when the FIFO was empty).
- **Pop latency.** `pop` is sampled at edge M. After edge M, `rd_keycode` shows the next entry, or `rd_valid`=0 if the FIFO is now empty.
- **Back-to-back pops** are legal every cycle.
- **Push rate.** A new push requires `keycode_valid` to be low for at least one sampled cycle in between, giving a maximum of one push per 2 cycles.
- **Volume latency.** `vol_status` and `vol_changed` update after the edge that detects `vupd`, which is 1 cycle after the rising input.
- **Storage.** Registers or distributed RAM; `rd_keycode` is combinational from `mem[rd_ptr]`, which is first-word-fall-through.

## Structure
- **Shared package `sb_pkg`:**
  - `SB_KEYQ_DEPTH`=16.
  - `vol_status` field constants: `VS_MUTE`=12, `VS_L_MSB`=11, `VS_L_LSB`=6, `VS_R_MSB`=5, `VS_R_LSB`=0.
- **Sub-module `sb_sync_fifo`:** parameters `W`, `DEPTH`. Ports `clk27`, `hw_reset_n`, `wr`, `wdata`, `rd`, `rdata`, `count`, `full`, `empty`.
- **Top of this block:** edge detection, the overflow flag and the volume register.

## Test plan
- **Single key.** Reset, then raise `keycode_valid` with `keycode`=16'h0A1B, held for 5 cycles → exactly one entry; after 1 edge `rd_valid`=1, `rd_keycode`=16'h0A1B, `fifo_count`=1. `pop` → `rd_valid`=0, `fifo_count`=0.
- **Overflow.** Push 17 distinct codes 16'h0100..16'h0110 with no pop → `fifo_count`=16, `overflow`=1. Pop 16 times and check the order is 16'h0100..16'h010F (16'h0110 dropped). `clr_overflow` → `overflow`=0.
- **Full with simultaneous pop.** Fill to 16, then push 16'h0200 in the same cycle as `pop` → `overflow` stays 0, count=16, and the last entry read out is 16'h0200.
- **Empty edge cases.** With the FIFO empty, `pop` alone → no change. Push 16'h0033 with `pop` in the same cycle → count=1, `rd_keycode`=16'h0033.
- **Volume.** `volume_db_valid` edge with `volume_db`=12'h3C5 and `is_muted`=0 → `vol_status`=13'h03C5, `vol_changed`=1. `vol_ack` in the same cycle as a new update → flag stays 1. `is_muted` toggles to 1 with no valid edge → bit 12 = 1, `vol_changed`=1.
- **Reset mid-run.** Assert `hw_reset_n`=0 with 5 entries queued and `keycode_valid` high → all outputs are 0 immediately. On release with `keycode_valid` still high → no spurious push.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared constants for the sound-box CPU-side event buffering.
package sb_pkg;

  localparam int unsigned SB_KEYQ_DEPTH = 16;

  // Bit positions inside vol_status = {muted, L[5:0], R[5:0]}.
  localparam int unsigned VS_MUTE  = 12;
  localparam int unsigned VS_L_MSB = 11;
  localparam int unsigned VS_L_LSB = 6;
  localparam int unsigned VS_R_MSB = 5;
  localparam int unsigned VS_R_LSB = 0;

endpackage

// File: rtl/sb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a separate occupancy counter.
module sb_sync_fifo #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk27,
  input  logic          hw_reset_n,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_acc, rd_acc;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rd_acc = rd & ~empty;
  // A write into a full FIFO is still legal when the head leaves in the same cycle.
  assign wr_acc = wr & (~full | rd_acc);
  // Held at zero while empty so stale storage never shows after reset.
  assign rdata  = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk27) begin
    if (wr_acc) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sb_event_queue.sv
// Buffers keyboard events and latches volume/mute state for lossless CPU reads.
module sb_event_queue
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_KEYQ_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk27,
  input  logic          hw_reset_n,
  input  logic [15:0]   keycode,
  input  logic          keycode_valid,
  input  logic          is_muted,
  input  logic [11:0]   volume_db,
  input  logic          volume_db_valid,
  input  logic          pop,
  output logic [15:0]   rd_keycode,
  output logic          rd_valid,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  input  logic          clr_overflow,
  output logic [12:0]   vol_status,
  output logic          vol_changed,
  input  logic          vol_ack
);

  logic        kv_q, vv_q;
  logic        push, vupd;
  logic        full, empty, drop;
  logic        overflow_q, overflow_d;
  logic [12:0] vol_status_q, vol_status_d;
  logic        vol_changed_q, vol_changed_d;

  assign push = keycode_valid & ~kv_q;
  assign vupd = volume_db_valid & ~vv_q;
  assign drop = push & full & ~(pop & ~empty);

  sb_sync_fifo #(
    .W     (16),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk27      (clk27),
    .hw_reset_n (hw_reset_n),
    .wr         (push),
    .wdata      (keycode),
    .rd         (pop),
    .rdata      (rd_keycode),
    .count      (fifo_count),
    .full       (full),
    .empty      (empty)
  );

  assign rd_valid    = ~empty;
  assign overflow    = overflow_q;
  assign vol_status  = vol_status_q;
  assign vol_changed = vol_changed_q;

  always_comb begin
    overflow_d    = overflow_q;
    vol_status_d  = vol_status_q;
    vol_changed_d = vol_changed_q;

    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;

    // Any update beats a concurrent ack so no change is ever lost.
    if (vupd) begin
      vol_status_d[VS_MUTE]           = is_muted;
      vol_status_d[VS_L_MSB:VS_L_LSB] = volume_db[11:6];
      vol_status_d[VS_R_MSB:VS_R_LSB] = volume_db[5:0];
      vol_changed_d                   = 1'b1;
    end else if (is_muted != vol_status_q[VS_MUTE]) begin
      vol_status_d[VS_MUTE] = is_muted;
      vol_changed_d         = 1'b1;
    end else if (vol_ack) begin
      vol_changed_d = 1'b0;
    end
  end

  // Edge detectors reset high: a valid held through reset release is not an event.
  always_ff @(posedge clk27 or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      kv_q          <= 1'b1;
      vv_q          <= 1'b1;
      overflow_q    <= 1'b0;
      vol_status_q  <= '0;
      vol_changed_q <= 1'b0;
    end else begin
      kv_q          <= keycode_valid;
      vv_q          <= volume_db_valid;
      overflow_q    <= overflow_d;
      vol_status_q  <= vol_status_d;
      vol_changed_q <= vol_changed_d;
    end
  end

endmodule

// File: tb/tb_sb_event_queue.sv
// Scoreboard bench for sb_event_queue: keys queued on push, compared on pop.
module tb_sb_event_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk27 = 1'b0;
  logic          hw_reset_n;
  logic [15:0]   keycode;
  logic          keycode_valid;
  logic          is_muted;
  logic [11:0]   volume_db;
  logic          volume_db_valid;
  logic          pop;
  logic [15:0]   rd_keycode;
  logic          rd_valid;
  logic [AW:0]   fifo_count;
  logic          overflow;
  logic          clr_overflow;
  logic [12:0]   vol_status;
  logic          vol_changed;
  logic          vol_ack;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [15:0] sb[$];
  logic        m_kv;
  logic        m_ovf;

  always #5 clk27 = ~clk27;

  sb_event_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk27           (clk27),
    .hw_reset_n      (hw_reset_n),
    .keycode         (keycode),
    .keycode_valid   (keycode_valid),
    .is_muted        (is_muted),
    .volume_db       (volume_db),
    .volume_db_valid (volume_db_valid),
    .pop             (pop),
    .rd_keycode      (rd_keycode),
    .rd_valid        (rd_valid),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow),
    .vol_status      (vol_status),
    .vol_changed     (vol_changed),
    .vol_ack         (vol_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Drive one cycle of key/pop stimulus at a negedge, update the scoreboard, check after the edge.
  task automatic do_cycle(input logic kv, input logic [15:0] kc, input logic p, input logic clr);
    logic push_ev, pop_ok, was_full;
    keycode       = kc;
    keycode_valid = kv;
    pop           = p;
    clr_overflow  = clr;
    push_ev  = kv & ~m_kv;
    pop_ok   = p && (sb.size() > 0);
    was_full = (sb.size() == DEPTH);
    if (pop_ok) check("pop_data", {16'h0, rd_keycode}, {16'h0, sb.pop_front()});
    if (push_ev && was_full && !pop_ok) m_ovf = 1'b1;
    else begin
      if (push_ev) sb.push_back(kc);
      if (clr) m_ovf = 1'b0;
    end
    m_kv = kv;
    @(negedge clk27);
    check("count", 32'(fifo_count), sb.size());
    check("rd_valid", 32'(rd_valid), 32'(sb.size() > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    keycode_valid = 1'b0;
    pop           = 1'b0;
    clr_overflow  = 1'b0;
  endtask

  task automatic push_key(input logic [15:0] kc, input logic p);
    do_cycle(1'b1, kc, p, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    hw_reset_n      = 1'b0;
    keycode         = '0;
    keycode_valid   = 1'b0;
    is_muted        = 1'b0;
    volume_db       = '0;
    volume_db_valid = 1'b0;
    pop             = 1'b0;
    clr_overflow    = 1'b0;
    vol_ack         = 1'b0;
    m_kv            = 1'b1;
    m_ovf           = 1'b0;

    repeat (2) @(negedge clk27);
    check("rst_rd_keycode", 32'(rd_keycode), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_vol_status", 32'(vol_status), 0);
    check("rst_vol_changed", 32'(vol_changed), 0);
    hw_reset_n = 1'b1;
    do_cycle(1'b0, 16'h0, 1'b0, 1'b0);

    // Single key held for several cycles yields one entry.
    do_cycle(1'b1, 16'h0A1B, 1'b0, 1'b0);
    check("single_head", 32'(rd_keycode), 32'h0A1B);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 16'h0A1B, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Overflow: 17 pushes, last dropped.
    for (int i = 0; i < 17; i++) push_key(16'h0100 + 16'(i), 1'b0);
    check("ovf_set", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b0, 1'b1);
    check("ovf_clr", 32'(overflow), 0);

    // Full with simultaneous pop: no drop, 16'h0200 becomes the tail.
    for (int i = 0; i < 16; i++) push_key(16'h0300 + 16'(i), 1'b0);
    push_key(16'h0200, 1'b1);
    check("full_pop_count", 32'(fifo_count), 16);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Empty edge cases.
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    do_cycle(1'b1, 16'h0033, 1'b1, 1'b0);
    check("empty_push_pop_head", 32'(rd_keycode), 32'h0033);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Volume register and change flag.
    volume_db       = 12'h3C5;
    volume_db_valid = 1'b1;
    @(negedge clk27);
    check("vol_status_1", 32'(vol_status), 32'h03C5);
    check("vol_changed_1", 32'(vol_changed), 1);
    volume_db_valid = 1'b0;
    @(negedge clk27);
    volume_db       = 12'h111;
    volume_db_valid = 1'b1;
    vol_ack         = 1'b1;
    @(negedge clk27);
    check("vol_status_2", 32'(vol_status), 32'h0111);
    check("vol_ack_vs_upd", 32'(vol_changed), 1);
    volume_db_valid = 1'b0;
    @(negedge clk27);
    check("vol_ack_clears", 32'(vol_changed), 0);
    vol_ack  = 1'b0;
    is_muted = 1'b1;
    @(negedge clk27);
    check("mute_status", 32'(vol_status), 32'h1111);
    check("mute_changed", 32'(vol_changed), 1);

    // Reset mid-run with entries queued and keycode_valid held high.
    for (int i = 0; i < 4; i++) push_key(16'h0500 + 16'(i), 1'b0);
    do_cycle(1'b1, 16'h0504, 1'b0, 1'b0);
    check("pre_reset_count", 32'(fifo_count), 5);
    keycode_valid = 1'b1;
    #2 hw_reset_n = 1'b0;
    #1;
    check("mid_rst_rd_keycode", 32'(rd_keycode), 0);
    check("mid_rst_rd_valid", 32'(rd_valid), 0);
    check("mid_rst_count", 32'(fifo_count), 0);
    check("mid_rst_vol_status", 32'(vol_status), 0);
    check("mid_rst_vol_changed", 32'(vol_changed), 0);
    is_muted = 1'b0;
    sb.delete();
    m_kv  = 1'b1;
    m_ovf = 1'b0;
    @(negedge clk27);
    hw_reset_n = 1'b1;
    do_cycle(1'b1, 16'h0504, 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0504, 1'b0, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b0, 1'b0);
    push_key(16'h0777, 1'b0);
    do_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
